mem_port_ctrl: RTL and testbench

Sequencer and arbiter for the multicycle CPU's single memory port. Accepts instruction-fetch and data (load/store) requests, grants one at a time, drives the memory address/enable/write lines for exactly one cycle, and counts out the fixed memory read latency. Strobes the memory data register load and acknowledges the winning requester when the access completes.

---
 rtl/mem_port_pkg.sv | 23 ++
 rtl/mem_port_ctrl_if.sv | 41 ++++
 rtl/mem_lat_counter.sv | 44 ++++
 rtl/mem_port_ctrl.sv | 161 ++++++++++++++++
 tb/tb_mem_port_ctrl.sv | 230 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_port_pkg.sv
//------------------------------------------------------------------------------
// Module  : mem_port_pkg
// Brief   : Shared types and constants for the memory port sequencer.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

package mem_port_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } state_t;

    localparam logic GRANT_FETCH = 1'b0;
    localparam logic GRANT_DATA  = 1'b1;
    localparam int   LAT_CNT_W   = 4;

endpackage

`default_nettype wire

// File: rtl/mem_port_ctrl_if.sv
//------------------------------------------------------------------------------
// Module  : mem_port_ctrl_if
// Brief   : Requester and memory-side bundle for mem_port_ctrl.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

interface mem_port_ctrl_if #(
    parameter int ADDR_W = 32,
    parameter int DATA_W = 32
);
    logic              if_req;
    logic [ADDR_W-1:0] if_addr;
    logic              if_ack;
    logic              dm_req;
    logic              dm_we;
    logic [ADDR_W-1:0] dm_addr;
    logic [DATA_W-1:0] dm_wdata;
    logic              dm_ack;
    logic              mem_en;
    logic              mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic              mdr_load;
    logic              grant_id;
    logic              busy;

    modport master (
        output if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        input  if_ack, dm_ack, mem_en, mem_we, mem_addr, mem_wdata,
               mdr_load, grant_id, busy
    );

    modport slave (
        input  if_req, if_addr, dm_req, dm_we, dm_addr, dm_wdata,
        output if_ack, dm_ack, mem_en, mem_we, mem_addr, mem_wdata,
               mdr_load, grant_id, busy
    );
endinterface

`default_nettype wire

// File: rtl/mem_lat_counter.sv
//------------------------------------------------------------------------------
// Module  : mem_lat_counter
// Brief   : Loadable down-counter; done flags the final wait cycle (count == 1).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_lat_counter
    import mem_port_pkg::*;
#(
    parameter int CNT_W = LAT_CNT_W
) (
    input  wire logic             clk,
    input  wire logic             reset,
    input  wire logic             load,
    input  wire logic [CNT_W-1:0] load_val,
    input  wire logic             dec,
    output logic                  done
);
    logic [CNT_W-1:0] count_q;
    logic [CNT_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (load) begin
            count_d = load_val;
        end else if (dec && (count_q != '0)) begin
            count_d = count_q - CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign done = (count_q == CNT_W'(1));

endmodule

`default_nettype wire

// File: rtl/mem_port_ctrl.sv
//------------------------------------------------------------------------------
// Module  : mem_port_ctrl
// Brief   : Single memory port arbiter/sequencer for fetch and data requests.
//           Define MEM_PORT_RR_EN for round-robin arbitration on ties.
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module mem_port_ctrl
    import mem_port_pkg::*;
#(
    parameter int ADDR_W  = 32,
    parameter int DATA_W  = 32,
    parameter int MEM_LAT = 2
) (
    input  wire logic       clk,
    input  wire logic       reset,
    mem_port_ctrl_if.slave  bus
);
    localparam logic [LAT_CNT_W-1:0] C_LAT_LOAD = LAT_CNT_W'(MEM_LAT - 1);

    state_t            state_q,     state_d;
    logic              grant_id_q,  grant_id_d;
    logic              we_q,        we_d;
    logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
    logic [DATA_W-1:0] mem_wdata_q, mem_wdata_d;
    logic              mem_en_q,    mem_en_d;
    logic              mem_we_q,    mem_we_d;
    logic              if_ack_q,    if_ack_d;
    logic              dm_ack_q,    dm_ack_d;
    logic              mdr_load_q,  mdr_load_d;
    logic              busy_q,      busy_d;

    logic w_pick_data;
    logic w_to_done;
    logic w_cnt_load;
    logic w_cnt_dec;
    logic w_cnt_done;

`ifdef MEM_PORT_RR_EN
    // On a tie, the requester not granted last time wins; reset leaves
    // grant_id at fetch, so data wins the first tie.
    assign w_pick_data = bus.dm_req && (!bus.if_req || (grant_id_q == GRANT_FETCH));
`else
    assign w_pick_data = bus.dm_req;
`endif

    mem_lat_counter #(
        .CNT_W (LAT_CNT_W)
    ) u_lat_cnt (
        .clk      (clk),
        .reset    (reset),
        .load     (w_cnt_load),
        .load_val (C_LAT_LOAD),
        .dec      (w_cnt_dec),
        .done     (w_cnt_done)
    );

    always_comb begin
        state_d     = state_q;
        grant_id_d  = grant_id_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_wdata_d = mem_wdata_q;
        mem_en_d    = 1'b0;
        mem_we_d    = 1'b0;
        w_to_done   = 1'b0;
        w_cnt_load  = 1'b0;
        w_cnt_dec   = 1'b0;

        case (state_q)
            IDLE: begin
                if (bus.if_req || bus.dm_req) begin
                    state_d  = ISSUE;
                    mem_en_d = 1'b1;
                    if (w_pick_data) begin
                        grant_id_d  = GRANT_DATA;
                        we_d        = bus.dm_we;
                        mem_we_d    = bus.dm_we;
                        mem_addr_d  = bus.dm_addr;
                        mem_wdata_d = bus.dm_wdata;
                    end else begin
                        grant_id_d  = GRANT_FETCH;
                        we_d        = 1'b0;
                        mem_addr_d  = bus.if_addr;
                    end
                end
            end
            ISSUE: begin
                w_cnt_load = 1'b1;
                if (MEM_LAT == 1) begin
                    state_d   = DONE;
                    w_to_done = 1'b1;
                end else begin
                    state_d   = WAIT;
                end
            end
            WAIT: begin
                if (w_cnt_done) begin
                    state_d   = DONE;
                    w_to_done = 1'b1;
                end else begin
                    w_cnt_dec = 1'b1;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Completion strobes are registered so they land in the DONE cycle.
        if_ack_d   = w_to_done && (grant_id_q == GRANT_FETCH);
        dm_ack_d   = w_to_done && (grant_id_q == GRANT_DATA);
        mdr_load_d = w_to_done && !we_q;
        busy_d     = (state_d != IDLE);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q     <= IDLE;
            grant_id_q  <= GRANT_FETCH;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            mem_en_q    <= 1'b0;
            mem_we_q    <= 1'b0;
            if_ack_q    <= 1'b0;
            dm_ack_q    <= 1'b0;
            mdr_load_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            grant_id_q  <= grant_id_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            mem_wdata_q <= mem_wdata_d;
            mem_en_q    <= mem_en_d;
            mem_we_q    <= mem_we_d;
            if_ack_q    <= if_ack_d;
            dm_ack_q    <= dm_ack_d;
            mdr_load_q  <= mdr_load_d;
            busy_q      <= busy_d;
        end
    end

    assign bus.if_ack    = if_ack_q;
    assign bus.dm_ack    = dm_ack_q;
    assign bus.mem_en    = mem_en_q;
    assign bus.mem_we    = mem_we_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.mdr_load  = mdr_load_q;
    assign bus.grant_id  = grant_id_q;
    assign bus.busy      = busy_q;

endmodule

`default_nettype wire

// File: tb/tb_mem_port_ctrl.sv
//------------------------------------------------------------------------------
// Module  : tb_mem_port_ctrl
// Brief   : Self-checking bench for mem_port_ctrl (MEM_LAT=2 and MEM_LAT=1).
// Rev     : 1.0  initial release
//------------------------------------------------------------------------------
`default_nettype none

module tb_mem_port_ctrl;
    import mem_port_pkg::*;

    localparam int LAT = 2;

    typedef struct packed {
        logic        gid;
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
    } exp_t;

    logic clk   = 1'b0;
    logic reset = 1'b1;
    int   cyc   = 0;

    int n_checks = 0;
    int n_errors = 0;

    exp_t sb[$];
    exp_t cur;
    logic pending  = 1'b0;
    int   iss_cyc  = 0;
    logic prev_en  = 1'b0;
    logic model_last = GRANT_FETCH;

    mem_port_ctrl_if #(.ADDR_W(32), .DATA_W(32)) b2 ();
    mem_port_ctrl_if #(.ADDR_W(32), .DATA_W(32)) b1 ();

    mem_port_ctrl #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (b2)
    );

    mem_port_ctrl #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(1)) dut_l1 (
        .clk   (clk),
        .reset (reset),
        .bus   (b1)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic tie_to_data();
`ifdef MEM_PORT_RR_EN
        return (model_last == GRANT_FETCH);
`else
        return 1'b1;
`endif
    endfunction

    // Scoreboard consumer for the MEM_LAT=2 instance
    always @(negedge clk) begin
        if (reset) begin
            pending = 1'b0;
            prev_en = 1'b0;
            sb.delete();
        end else begin
            if (b2.if_ack || b2.dm_ack) begin
                chk("ack_excl", b2.if_ack & b2.dm_ack, 0);
                chk("ack_pending", pending, 1);
                if (pending) begin
                    chk("ack_id", {b2.dm_ack, b2.if_ack}, cur.gid ? 2'b10 : 2'b01);
                    chk("ack_lat", cyc - iss_cyc, LAT);
                    chk("mdr_load", b2.mdr_load, !cur.we);
                    chk("addr_hold", b2.mem_addr, cur.addr);
                    chk("grant_id", b2.grant_id, cur.gid);
                    pending = 1'b0;
                end
            end else if (b2.mdr_load) begin
                chk("mdr_stray", b2.mdr_load, 0);
            end
            if (b2.mem_en) begin
                chk("en_single", prev_en, 0);
                chk("en_expected", sb.size() != 0, 1);
                chk("busy", b2.busy, 1);
                if (sb.size() != 0) begin
                    cur     = sb.pop_front();
                    pending = 1'b1;
                    iss_cyc = cyc;
                    chk("iss_addr", b2.mem_addr, cur.addr);
                    chk("iss_we", b2.mem_we, cur.we);
                    chk("iss_gid", b2.grant_id, cur.gid);
                    if (cur.we) chk("iss_wdata", b2.mem_wdata, cur.wdata);
                end
            end else if (b2.mem_we) begin
                chk("we_stray", b2.mem_we, 0);
            end
            prev_en = b2.mem_en;
        end
    end

    task automatic run(input logic do_f, input logic [31:0] fa,
                       input logic do_d, input logic dwe,
                       input logic [31:0] da, input logic [31:0] dd,
                       input logic poke);
        exp_t ef, ed;
        int   n;
        logic seen_en;
        ef = '{gid: GRANT_FETCH, we: 1'b0, addr: fa, wdata: 32'h0};
        ed = '{gid: GRANT_DATA,  we: dwe,  addr: da, wdata: dd};
        if (do_f && do_d) begin
            if (tie_to_data()) begin
                sb.push_back(ed); sb.push_back(ef); model_last = GRANT_FETCH;
            end else begin
                sb.push_back(ef); sb.push_back(ed); model_last = GRANT_DATA;
            end
        end else if (do_f) begin
            sb.push_back(ef); model_last = GRANT_FETCH;
        end else if (do_d) begin
            sb.push_back(ed); model_last = GRANT_DATA;
        end
        @(negedge clk);
        b2.if_req = do_f; b2.if_addr = fa;
        b2.dm_req = do_d; b2.dm_we = dwe; b2.dm_addr = da; b2.dm_wdata = dd;
        n = 0;
        seen_en = 1'b0;
        while ((b2.if_req || b2.dm_req) && n < 40) begin
            @(negedge clk);
            n++;
            if (b2.mem_en && !seen_en) begin
                seen_en = 1'b1;
                if (!(do_f && do_d)) chk("issue_lat", n, 1);
            end
            if (poke && seen_en && !b2.mem_en) b2.dm_addr = ~da;
            if (b2.if_ack) b2.if_req = 1'b0;
            if (b2.dm_ack) b2.dm_req = 1'b0;
        end
        chk("req_done", {b2.if_req, b2.dm_req}, 0);
        b2.if_req = 1'b0;
        b2.dm_req = 1'b0;
    endtask

    initial begin
        int n;
        b2.if_req = 0; b2.if_addr = '0; b2.dm_req = 0; b2.dm_we = 0;
        b2.dm_addr = '0; b2.dm_wdata = '0;
        b1.if_req = 0; b1.if_addr = '0; b1.dm_req = 0; b1.dm_we = 0;
        b1.dm_addr = '0; b1.dm_wdata = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", b2.busy, 0);
        chk("rst_mem_en", b2.mem_en, 0);
        chk("rst_mem_addr", b2.mem_addr, 0);
        chk("rst_mem_wdata", b2.mem_wdata, 0);
        chk("rst_grant_id", b2.grant_id, 0);
        chk("rst_acks", {b2.if_ack, b2.dm_ack, b2.mdr_load}, 0);
        chk("rst_l1_busy", b1.busy, 0);
        reset = 1'b0;

        run(1, 32'h0000_0040, 0, 0, 32'h0, 32'h0, 0);
        run(0, 32'h0, 1, 1, 32'h0000_0100, 32'hDEAD_BEEF, 1);
        run(0, 32'h0, 1, 0, 32'h0000_0180, 32'h0, 0);
        run(1, 32'h0000_0300, 1, 0, 32'h0000_0400, 32'h0, 0);
        run(1, 32'h0000_0304, 1, 1, 32'h0000_0404, 32'h1234_5678, 0);
        run(1, 32'h0000_0308, 1, 0, 32'h0000_0408, 32'h0, 0);

        // Abandon an access mid-WAIT
        sb.push_back('{gid: GRANT_DATA, we: 1'b0, addr: 32'h500, wdata: 32'h0});
        @(negedge clk);
        b2.dm_req = 1; b2.dm_we = 0; b2.dm_addr = 32'h500;
        n = 0;
        while (!b2.mem_en && n < 10) begin @(negedge clk); n++; end
        chk("rw_issue", b2.mem_en, 1);
        @(negedge clk);
        reset = 1'b1; b2.dm_req = 0;
        pending = 1'b0; sb.delete();
        @(negedge clk);
        chk("rw_busy", b2.busy, 0);
        chk("rw_mem_en", b2.mem_en, 0);
        chk("rw_mem_addr", b2.mem_addr, 0);
        chk("rw_grant_id", b2.grant_id, 0);
        chk("rw_outs", {b2.dm_ack, b2.if_ack, b2.mdr_load, b2.mem_we}, 0);
        @(negedge clk);
        reset = 1'b0;
        model_last = GRANT_FETCH;
        repeat (6) @(negedge clk);
        run(1, 32'h0000_0600, 0, 0, 32'h0, 32'h0, 0);
        run(1, 32'h0000_0700, 1, 0, 32'h0000_0800, 32'h0, 0);

        // MEM_LAT=1 instance: ack directly after ISSUE
        @(negedge clk);
        b1.if_req = 1; b1.if_addr = 32'h44;
        n = 0;
        while (n < 10) begin
            @(negedge clk); n++;
            if (b1.mem_en) break;
        end
        chk("l1_issue_lat", n, 1);
        chk("l1_addr", b1.mem_addr, 32'h44);
        @(negedge clk);
        chk("l1_ack", b1.if_ack, 1);
        chk("l1_mdr", b1.mdr_load, 1);
        chk("l1_dm_ack", b1.dm_ack, 0);
        b1.if_req = 0;
        @(negedge clk);
        chk("l1_ack_pulse", b1.if_ack, 0);
        chk("l1_idle", b1.busy, 0);

        repeat (3) @(negedge clk);
        chk("sb_empty", sb.size(), 0);
        chk("no_pending", pending, 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

endmodule

`default_nettype wire
